pm_alu_unit: RTL

Power-managed, width-parametrised ALU unit with an integrated power sequencer. It combines the ALU datapath with an FSM that drives isolation, power enable, state save and restore. It replaces the previous arrangement, where the top level drove `alu_pwr_en`/`iso_en` directly and clamped the result combinationally. It sits between the system controller (power requests) and the datapath consumer of `result`.

---
 rtl/pm_alu_unit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/pm_alu_unit.sv
// pm_alu_unit: width-parametrised ALU with an integrated power sequencer.
//
// The sequencer walks ON -> (DRAIN) -> ISO -> SAVE -> OFF -> PWRUP -> RESTORE -> ON.
// While isolated, `result` is clamped to CLAMP_VAL. In OFF, the internal result
// register and the MUL state are cleared, which models loss of domain state.
//
// Optional feature macro: PM_ALU_RETENTION_EN
//   defined   : SAVE copies the result into an always-on retention register,
//               and RESTORE reloads it.
//   undefined : no retention register; RESTORE loads 0 (timing identical).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   a, b, opcode, start operands / operation / request (accepted when ready)
//   ready               ON state and ALU idle
//   done                1-cycle pulse when result updates
//   start_err           1-cycle pulse for a start that arrives while not ready
//   result              ALU result, or CLAMP_VAL while iso_en
//   pd_req, pu_req      power-down / power-up request levels
//   pwr_en, iso_en      power switch enable, isolation enable (registered)
//   pwr_state           current sequencer state encoding
module pm_alu_unit #(
    parameter int unsigned      WIDTH      = 16,
    parameter logic [WIDTH-1:0] CLAMP_VAL  = '0,
    parameter int unsigned      ISO_DLY    = 2,
    parameter int unsigned      PWR_UP_DLY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    input  logic             start,
    output logic             ready,
    output logic             done,
    output logic             start_err,
    output logic [WIDTH-1:0] result,
    input  logic             pd_req,
    input  logic             pu_req,
    output logic             pwr_en,
    output logic             iso_en,
    output logic [2:0]       pwr_state
);

    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned CW   = $clog2(WIDTH + 1);
    localparam int unsigned DMAX = (ISO_DLY > PWR_UP_DLY) ? ISO_DLY : PWR_UP_DLY;
    localparam int unsigned DW   = $clog2(DMAX + 1);

    typedef enum logic [2:0] {
        S_ON      = 3'd0,
        S_DRAIN   = 3'd1,
        S_ISO     = 3'd2,
        S_SAVE    = 3'd3,
        S_OFF     = 3'd4,
        S_PWRUP   = 3'd5,
        S_RESTORE = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic            pwr_en_q, iso_en_q;

    logic [WIDTH-1:0] res_q;
    logic             done_q, start_err_q, busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
    logic [WIDTH-1:0] alu_r, mul_sum, restore_val;
    logic             accept, is_mul, mul_last;

    assign ready    = (state_q == S_ON) && !busy_q;
    assign accept   = start && ready;
    assign is_mul   = (opcode == 3'd7);
    // Final busy cycle of a MUL: done is visible, busy drops at the next edge.
    assign mul_last = busy_q && (cnt_q == CW'(WIDTH));

    // ---------------- power sequencer ----------------
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        case (state_q)
            // A MUL accepted in the same cycle as pd_req must still be drained.
            S_ON:      if (pd_req) state_d = (busy_q || (accept && is_mul)) ? S_DRAIN : S_ISO;
            S_DRAIN:   if (!busy_q || mul_last) state_d = S_ISO;
            S_ISO: begin
                if (dly_q == DW'(ISO_DLY - 1)) state_d = S_SAVE;
                else                           dly_d   = dly_q + 1'b1;
            end
            S_SAVE:    state_d = S_OFF;
            S_OFF:     if (pu_req) state_d = S_PWRUP;
            S_PWRUP: begin
                if (dly_q == DW'(PWR_UP_DLY - 1)) state_d = S_RESTORE;
                else                              dly_d   = dly_q + 1'b1;
            end
            S_RESTORE: state_d = S_ON;
            default:   state_d = S_ON;
        endcase
        if (state_d != state_q) dly_d = '0;
    end

    // Power outputs are registered off the next state so they change with pwr_state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_ON;
            dly_q    <= '0;
            pwr_en_q <= 1'b1;
            iso_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            pwr_en_q <= (state_d != S_OFF);
            iso_en_q <= !((state_d == S_ON) || (state_d == S_DRAIN));
        end
    end

    // ---------------- ALU datapath ----------------
    always_comb begin
        alu_r = '0;
        case (opcode)
            3'd0:    alu_r = a + b;
            3'd1:    alu_r = a - b;
            3'd2:    alu_r = a & b;
            3'd3:    alu_r = a | b;
            3'd4:    alu_r = a ^ b;
            3'd5:    alu_r = a << b[SHW-1:0];
            3'd6:    alu_r = a >> b[SHW-1:0];
            default: alu_r = '0;  // MUL runs iteratively
        endcase
    end

    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // MUL: bit 0 is folded in on accept, bits 1..WIDTH-1 on the following
    // cycles, so the product lands at N+WIDTH-1 and done shows at N+WIDTH;
    // one more cycle at cnt==WIDTH keeps ready low through N+WIDTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q       <= '0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
        end else begin
            done_q      <= 1'b0;
            start_err_q <= start && !ready;
            if (state_q == S_OFF) begin
                res_q    <= '0;
                busy_q   <= 1'b0;
                cnt_q    <= '0;
                acc_q    <= '0;
                mcand_q  <= '0;
                mplier_q <= '0;
            end else if (state_q == S_RESTORE) begin
                res_q <= restore_val;
            end else if (accept) begin
                if (is_mul) begin
                    busy_q   <= 1'b1;
                    cnt_q    <= CW'(1);
                    acc_q    <= b[0] ? a : '0;
                    mcand_q  <= a << 1;
                    mplier_q <= b >> 1;
                end else begin
                    res_q  <= alu_r;
                    done_q <= 1'b1;
                end
            end else if (busy_q) begin
                if (cnt_q < CW'(WIDTH)) begin
                    acc_q    <= mul_sum;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        res_q  <= mul_sum;
                        done_q <= 1'b1;
                    end
                end else begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

`ifdef PM_ALU_RETENTION_EN
    // Always-on retention register: survives OFF, cleared only by reset.
    logic [WIDTH-1:0] ret_q;
    always_ff @(posedge clk) begin
        if (!rst_n)                 ret_q <= '0;
        else if (state_q == S_SAVE) ret_q <= res_q;
    end
    assign restore_val = ret_q;
`else
    assign restore_val = '0;
`endif

    assign done      = done_q;
    assign start_err = start_err_q;
    assign result    = iso_en_q ? CLAMP_VAL : res_q;
    assign pwr_en    = pwr_en_q;
    assign iso_en    = iso_en_q;
    assign pwr_state = state_q;

endmodule
